fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Program-counter and fetch-control stage directly upstream of InstructionMemory.
//  - Holds the PC and drives InstructionAddress.
//  - Picks the next PC from sequential, branch and jump sources.
//  - Gates the returned instruction with a valid flag and a NOP substitute.
//  - Traps misaligned or out-of-range fetches; halts on EBREAK.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; must be 4-byte aligned
//  IMEM_SIZE `MEM_SIZE      instruction memory size in bytes; bounds-check limit
// PORTS
//  clk                 in   1   system clock, rising edge
//  reset               in   1   synchronous, active-high reset
//  Stall               in   1   hold PC and state this cycle
//  BranchTaken         in   1   conditional branch resolved taken
//  BranchTarget        in   32  branch destination address
//  Jump                in   1   JAL/JALR redirect
//  JumpTarget          in   32  jump destination address
//  ReadInstruction     in   32  word returned by InstructionMemory
//  InstructionAddress  out  32  address to InstructionMemory; equals PC
//  PC                  out  32  current PC
//  PCPlus4             out  32  PC+4, for the JAL/JALR link value
//  Instruction         out  32  ReadInstruction when Valid, else `NOP_INSTR
//  Valid               out  1   instruction is live (state RUN)
//  Halted              out  1   state HALT
//  Fault               out  1   state FAULT
//  FaultCause          out  2   00 none, 01 misaligned target, 10 out of range
//  FaultPC             out  32  PC of the instruction that caused the fault
//  RetireCount         out  32  number of instructions retired
// BEHAVIOUR
//  Reset (any state, any cycle, including mid-stall or in FAULT/HALT):
//   state=BOOT, PC=RESET_PC, FaultCause=0, FaultPC=0, RetireCount=0.
//   Outputs: Valid=0, Halted=0, Fault=0, Instruction=`NOP_INSTR.
//  FSM states: BOOT, RUN, HALT, FAULT.
//   BOOT: exactly one cycle, PC unchanged, then RUN (Stall ignored in BOOT).
//   RUN: Valid=1. Next-PC priority:
//    Stall > Jump > BranchTaken > PC+4.
//    A redirect arriving while Stall=1 is dropped; the decoder re-asserts it.
//   HALT and FAULT are sticky; only reset leaves them. PC is frozen, Valid=0.
//  Fetch latency: combinational. InstructionAddress=PC, and Instruction follows
//   ReadInstruction in the same cycle. PC updates on the rising edge.
//  Candidate check (RUN, Stall=0), on the selected next PC (NPC):
//   NPC[1:0]!=0           -> FAULT, cause 01.
//   NPC > IMEM_SIZE-4     -> FAULT, cause 10.
//   Misaligned wins if both conditions are true.
//   The PC+4 path is checked too, so walking off the end of memory faults
//    (cause 10); there is no wrap to 0.
//   On fault: FaultPC=PC and PC holds (it is not loaded with NPC).
//   The faulting instruction still retires (it executed).
//  EBREAK: Valid=1, Stall=0, ReadInstruction==`EBREAK_INSTR -> HALT next cycle.
//   PC holds at the EBREAK address. EBREAK retires.
//   EBREAK takes precedence over a simultaneous fault check.
//  RetireCount: +1 on each RUN cycle with Stall=0. Modulo 2^32 (wraps silently).
//  All arithmetic is 32-bit unsigned; the PC+4 carry-out is discarded.
//  All outputs are registered state or simple decodes of it; no input-to-output
//   combinational path except ReadInstruction -> Instruction.
// STRUCTURE
//  Add to RISCV_PKG.vh:
//   `NOP_INSTR=32'h0000_0013, `EBREAK_INSTR=32'h0010_0073.
//   FSM state encodings (2 bits).
//   FaultCause codes.
//   `RESET_PC default.
//  Sub-module next_pc_sel (combinational):
//   Priority mux plus alignment and bounds check.
//   Outputs NPC, npc_fault, npc_cause.
//  The top level keeps the PC register, FSM, fault latch and retire counter.
// TESTING
//  1 reset 3 cycles, release -> cycle 1 BOOT with Valid=0 and PC=0;
//    then PC 0,4,8 with Valid=1 and RetireCount 1,2,3.
//  2 PC=0x10, Jump=1 JumpTarget=0x40 with BranchTaken=1 BranchTarget=0x80
//    -> next PC=0x40.
//  3 PC=0x20, Stall=1 for 2 cycles with BranchTaken=1 -> PC stays 0x20 and
//    RetireCount is unchanged; release -> PC=0x24.
//  4 Jump to 0x42 -> Fault=1, FaultCause=01, FaultPC=old PC, PC unchanged,
//    Instruction=NOP. Hold 5 cycles, then reset -> BOOT.
//  5 PC=IMEM_SIZE-4 sequential -> FaultCause=10.
//    Also BranchTarget=IMEM_SIZE -> FaultCause=10.
//  6 ReadInstruction=32'h0010_0073 at PC=0x8 -> Halted=1 next cycle, PC=0x8,
//    Valid=0. Redirects are ignored; reset mid-HALT restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch stage: special instruction words, FSM states,
// fault causes and default memory geometry.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR     = 32'h0010_0073;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned MEM_SIZE         = 1024;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_RANGE    = 2'b10
  } cause_t;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority mux (Stall > Jump > Branch > PC+4) with alignment and
// instruction-memory bounds check on the selected candidate.
module fetch_unit_next_pc_sel
  import fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_SIZE = MEM_SIZE
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] npc,
  output logic        npc_fault,
  output cause_t      npc_cause
);

  localparam logic [31:0] LAST_WORD = 32'(IMEM_SIZE - 4);

  always_comb begin
    npc = pc + 32'd4;
    if (stall) begin
      npc = pc;
    end else if (jump) begin
      npc = jump_target;
    end else if (branch_taken) begin
      npc = branch_target;
    end
  end

  // Misalignment is reported ahead of range when a target is both.
  always_comb begin
    npc_fault = 1'b0;
    npc_cause = CAUSE_NONE;
    if (npc[1:0] != 2'b00) begin
      npc_fault = 1'b1;
      npc_cause = CAUSE_MISALIGN;
    end else if (npc > LAST_WORD) begin
      npc_fault = 1'b1;
      npc_cause = CAUSE_RANGE;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, BOOT/RUN/HALT/FAULT control, fault latch and
// retire counter. Instruction is the only combinational path from an input.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_SIZE = MEM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] ReadInstruction,
  output logic [31:0] InstructionAddress,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] Instruction,
  output logic        Valid,
  output logic        Halted,
  output logic        Fault,
  output logic [1:0]  FaultCause,
  output logic [31:0] FaultPC,
  output logic [31:0] RetireCount
);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] fault_pc, fault_pc_nxt;
  logic [31:0] retire, retire_nxt;
  cause_t      cause, cause_nxt;
  logic [31:0] npc;
  logic        npc_fault;
  cause_t      npc_cause;

  fetch_unit_next_pc_sel #(
    .IMEM_SIZE(IMEM_SIZE)
  ) u_next_pc_sel (
    .pc           (pc),
    .stall        (Stall),
    .jump         (Jump),
    .jump_target  (JumpTarget),
    .branch_taken (BranchTaken),
    .branch_target(BranchTarget),
    .npc          (npc),
    .npc_fault    (npc_fault),
    .npc_cause    (npc_cause)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      cause    <= CAUSE_NONE;
      fault_pc <= 32'd0;
      retire   <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      cause    <= cause_nxt;
      fault_pc <= fault_pc_nxt;
      retire   <= retire_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    cause_nxt    = cause;
    fault_pc_nxt = fault_pc;
    retire_nxt   = retire;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (!Stall) begin
          // Both EBREAK and a faulting instruction have executed, so they retire.
          retire_nxt = retire + 32'd1;
          if (ReadInstruction == EBREAK_INSTR) begin
            state_nxt = ST_HALT;
          end else if (npc_fault) begin
            state_nxt    = ST_FAULT;
            cause_nxt    = npc_cause;
            fault_pc_nxt = pc;
          end else begin
            pc_nxt = npc;
          end
        end
      end
      default: ;
    endcase
  end

  assign InstructionAddress = pc;
  assign PC                 = pc;
  assign PCPlus4            = pc + 32'd4;
  assign Valid              = (state == ST_RUN);
  assign Halted             = (state == ST_HALT);
  assign Fault              = (state == ST_FAULT);
  assign FaultCause         = cause;
  assign FaultPC            = fault_pc;
  assign RetireCount        = retire;
  assign Instruction        = Valid ? ReadInstruction : NOP_INSTR;

endmodule
